// File: rtl/voting_machine_multi_pkg.sv
// Shared types and helpers for the multi-candidate ballot counter.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VOTE   = 2'b01,
    HOLD   = 2'b10,
    FINISH = 2'b11
  } vm_state_t;

  // Widest candidate bus the popcount helper covers.
  localparam int unsigned MAX_CAND = 32;

  function automatic int unsigned popcount(input logic [MAX_CAND-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CAND; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the value maxv itself.
  function automatic int unsigned val_w(input int unsigned maxv);
    return (maxv > 0) ? $clog2(maxv + 1) : 1;
  endfunction

endpackage

// File: rtl/voting_machine_multi_argmax.sv
// Combinational argmax over the flat count bus: lowest index holding the
// maximum, plus a tie flag when more than one candidate shares that maximum.
module vm_argmax
  import voting_pkg::*;
#(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 16
) (
  input  logic [N_CAND*CNT_W-1:0]  cnt_i,
  output logic [$clog2(N_CAND)-1:0] idx_o,
  output logic                      tie_o
);

  logic [CNT_W-1:0] max_v;
  int unsigned      n_eq;

  // Strict greater-than keeps the lowest index on equal values.
  always_comb begin
    max_v = cnt_i[0 +: CNT_W];
    idx_o = '0;
    for (int i = 1; i < N_CAND; i++) begin
      if (cnt_i[i*CNT_W +: CNT_W] > max_v) begin
        max_v = cnt_i[i*CNT_W +: CNT_W];
        idx_o = ($clog2(N_CAND))'(i);
      end
    end
  end

  // Count how many candidates reach the maximum; all-zero counts as a tie.
  always_comb begin
    n_eq = 0;
    for (int i = 0; i < N_CAND; i++) begin
      if (cnt_i[i*CNT_W +: CNT_W] == max_v) n_eq = n_eq + 1;
    end
    tie_o = (n_eq > 1);
  end

endmodule

// File: rtl/voting_machine_multi.sv
// N-candidate ballot counter: one vote per falling edge on a candidate line,
// lockout after every ballot, simultaneous falls tallied as spoiled, saturating
// counters, results published on poll close.
// Optional feature: define VM_WINNER_EN to add winner/tie outputs.
module voting_machine_multi
  import voting_pkg::*;
#(
  parameter int N_CAND   = 4,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CAND-1:0]                 cand_vote,
  input  logic                              voting_done,
  output logic [N_CAND*CNT_W-1:0]           count,
  output logic [CNT_W+$clog2(N_CAND)-1:0]   total_votes,
  output logic [CNT_W-1:0]                  invalid_votes,
  output logic                              results_valid,
  output logic                              busy
`ifdef VM_WINNER_EN
  ,
  output logic [$clog2(N_CAND)-1:0]         winner,
  output logic                              tie
`endif
);

  localparam int TOT_W  = CNT_W + $clog2(N_CAND);
  localparam int HOLD_W = val_w(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  vm_state_t                 state_q, state_d;
  logic [N_CAND-1:0]         prev_q;
  logic [N_CAND-1:0]         fall;
  int unsigned               n_fall;
  logic [N_CAND*CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]          inv_q, inv_d;
  logic [HOLD_W-1:0]         hold_q, hold_d, hold_inc;
  logic                      valid_q, valid_d;
  logic                      load;
  logic [TOT_W-1:0]          total_sum;

  logic [N_CAND*CNT_W-1:0]   count_q;
  logic [TOT_W-1:0]          total_q;
  logic [CNT_W-1:0]          invalid_q;
  logic                      busy_q;

  assign fall     = prev_q & ~cand_vote;
  assign n_fall   = popcount(MAX_CAND'(fall));
  assign hold_inc = hold_q + 1'b1;

  // Sum of the live counters, captured when results are published.
  always_comb begin
    total_sum = '0;
    for (int i = 0; i < N_CAND; i++) begin
      total_sum = total_sum + TOT_W'(cnt_q[i*CNT_W +: CNT_W]);
    end
  end

  // Next state, counter updates and publish strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = VOTE;
        cnt_d   = '0;
        inv_d   = '0;
        hold_d  = '0;
      end
      VOTE: begin
        if (voting_done) begin
          state_d = FINISH;
        end else if (n_fall == 1) begin
          for (int i = 0; i < N_CAND; i++) begin
            if (fall[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
              cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
          end
          state_d = HOLD;
          hold_d  = '0;
          valid_d = 1'b0;
        end else if (n_fall > 1) begin
          if (inv_q != CNT_MAX) inv_d = inv_q + 1'b1;
          state_d = HOLD;
          hold_d  = '0;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (voting_done) begin
          state_d = FINISH;
        end else if (hold_inc == HOLD_W'(HOLD_CYC)) begin
          state_d = VOTE;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      FINISH: begin
        if (!voting_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load = (state_d == FINISH) && (state_q != FINISH);
    if (load) valid_d = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Edge sampler, live counters and published results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      inv_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      total_q   <= '0;
      invalid_q <= '0;
    end else begin
      prev_q  <= cand_vote;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == VOTE) || (state_d == HOLD);
      if (load) begin
        count_q   <= cnt_q;
        total_q   <= total_sum;
        invalid_q <= inv_q;
      end
    end
  end

  assign count         = count_q;
  assign total_votes   = total_q;
  assign invalid_votes = invalid_q;
  assign results_valid = valid_q;
  assign busy          = busy_q;

`ifdef VM_WINNER_EN
  logic [$clog2(N_CAND)-1:0] win_c, winner_q;
  logic                      tie_c, tie_q;

  vm_argmax #(
    .N_CAND (N_CAND),
    .CNT_W  (CNT_W)
  ) u_argmax (
    .cnt_i (cnt_q),
    .idx_o (win_c),
    .tie_o (tie_c)
  );

  // Winner/tie captured together with the counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else if (load) begin
      winner_q <= win_c;
      tie_q    <= tie_c;
    end
  end

  assign winner = winner_q;
  assign tie    = tie_q;
`endif

endmodule

// File: tb/tb_voting_machine_multi.sv
// Self-checking bench for voting_machine_multi (N_CAND=4, CNT_W=4, HOLD_CYC=3).
module tb_voting_machine_multi;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int TW = W + 2;
  localparam int CMAX = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cand_vote;
  logic            voting_done;
  logic [N*W-1:0]  count;
  logic [TW-1:0]   total_votes;
  logic [W-1:0]    invalid_votes;
  logic            results_valid;
  logic            busy;
`ifdef VM_WINNER_EN
  logic [1:0]      winner;
  logic            tie;
`endif

  voting_machine_multi #(.N_CAND(N), .CNT_W(W), .HOLD_CYC(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .cand_vote     (cand_vote),
    .voting_done   (voting_done),
    .count         (count),
    .total_votes   (total_votes),
    .invalid_votes (invalid_votes),
    .results_valid (results_valid),
    .busy          (busy)
`ifdef VM_WINNER_EN
    ,
    .winner        (winner),
    .tie           (tie)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] cnt;
    logic [TW-1:0]  tot;
    logic [W-1:0]   inv;
    logic [1:0]     win;
    logic           tie;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   mdl_cnt[N];
  int   mdl_inv;
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
    mdl_inv = 0;
  endtask

  // One accepted ballot, then exactly the lockout period.
  task automatic vote(input int c);
    cand_vote[c] = 1'b0;
    tick();
    cand_vote[c] = 1'b1;
    if (mdl_cnt[c] < CMAX) mdl_cnt[c]++;
    repeat (H) tick();
  endtask

  // Push expected results, close the poll (optionally with lines dropping on
  // the same edge), then pop and compare on the first cycle in FINISH.
  task automatic close_poll(input string tag, input logic [N-1:0] drop_mask);
    exp_t e, got;
    int   tot, mx, cnt_eq;
    tot = 0; mx = mdl_cnt[0]; e.win = 2'd0; cnt_eq = 0;
    for (int i = 0; i < N; i++) begin
      e.cnt[i*W +: W] = W'(mdl_cnt[i]);
      tot += mdl_cnt[i];
      if (mdl_cnt[i] > mx) begin mx = mdl_cnt[i]; e.win = 2'(i); end
    end
    for (int i = 0; i < N; i++) if (mdl_cnt[i] == mx) cnt_eq++;
    e.tot = TW'(tot);
    e.inv = W'(mdl_inv);
    e.tie = (cnt_eq > 1);
    sb_q.push_back(e);
    cand_vote   = cand_vote & ~drop_mask;
    voting_done = 1'b1;
    tick();
    cand_vote = cand_vote | drop_mask;
    checks++;
    if (results_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid: got %b expected 1", tag, results_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy: got %b expected 0", tag, busy);
    end
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      last_exp = got;
      checks++;
      if (count !== got.cnt) begin
        errors++; $display("FAIL %s count: got %h expected %h", tag, count, got.cnt);
      end
      checks++;
      if (total_votes !== got.tot) begin
        errors++; $display("FAIL %s total: got %0d expected %0d", tag, total_votes, got.tot);
      end
      checks++;
      if (invalid_votes !== got.inv) begin
        errors++; $display("FAIL %s invalid: got %0d expected %0d", tag, invalid_votes, got.inv);
      end
`ifdef VM_WINNER_EN
      checks++;
      if (winner !== got.win) begin
        errors++; $display("FAIL %s winner: got %0d expected %0d", tag, winner, got.win);
      end
      checks++;
      if (tie !== got.tie) begin
        errors++; $display("FAIL %s tie: got %b expected %b", tag, tie, got.tie);
      end
`endif
    end
  endtask

  task automatic reopen();
    voting_done = 1'b0;
    tick();
    tick();
    model_clear();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reopen busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cand_vote = '1; voting_done = 1'b0;
    model_clear();
    tick(); tick();
    checks++;
    if (count !== '0 || total_votes !== '0 || invalid_votes !== '0) begin
      errors++; $display("FAIL reset outputs: got %h/%0d/%0d expected 0/0/0", count, total_votes, invalid_votes);
    end
    checks++;
    if (results_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset flags: got valid=%b busy=%b expected 0 0", results_valid, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset release busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_single_vote();
    vote(2);
    checks++;
    if (results_valid !== 1'b0) begin
      errors++; $display("FAIL single pre-close valid: got %b expected 0", results_valid);
    end
    close_poll("single", '0);
  endtask

  task automatic test_spoiled_and_lockout();
    reopen();
    checks++;
    if (results_valid !== 1'b1 || count !== last_exp.cnt) begin
      errors++; $display("FAIL reopen held: got valid=%b count=%h expected 1 %h", results_valid, count, last_exp.cnt);
    end
    cand_vote[0] = 1'b0; cand_vote[3] = 1'b0;
    tick();
    mdl_inv++;
    checks++;
    if (results_valid !== 1'b0) begin
      errors++; $display("FAIL spoiled valid clear: got %b expected 0", results_valid);
    end
    cand_vote = '1;
    tick(); tick();
    cand_vote[1] = 1'b0;   // seen on the last HOLD cycle: must be ignored
    tick();
    cand_vote[1] = 1'b1;
    tick();
    vote(1);
    close_poll("spoiled", '0);
  endtask

  task automatic test_saturation();
    reopen();
    for (int k = 0; k < 20; k++) vote(0);
    close_poll("saturate", '0);
  endtask

  task automatic test_done_priority();
    reopen();
    vote(1);
    close_poll("done_prio", 4'b0010);
  endtask

  task automatic test_reset_mid_hold();
    reopen();
    cand_vote[2] = 1'b0;
    tick();
    cand_vote = '1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midhold busy: got %b expected 1", busy);
    end
    rst = 1'b0;
    tick();
    model_clear();
    checks++;
    if (count !== '0 || total_votes !== '0 || invalid_votes !== '0 || results_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midhold reset: got %h/%0d/%0d/%b/%b expected all 0", count, total_votes, invalid_votes, results_valid, busy);
    end
    cand_vote[0] = 1'b0;   // dropped while in reset, never high afterwards
    tick();
    rst = 1'b1;
    tick();
    tick();
    cand_vote[0] = 1'b1;
    tick();
    vote(3);
    close_poll("midhold", '0);
  endtask

`ifdef VM_WINNER_EN
  task automatic test_winner();
    reopen();
    repeat (3) vote(0);
    repeat (5) vote(1);
    repeat (5) vote(2);
    vote(3);
    close_poll("winner_tie", '0);
    reopen();
    close_poll("winner_zero", '0);
    reopen();
    vote(3); vote(3); vote(1);
    close_poll("winner_clear", '0);
  endtask
`endif

  task automatic test_back_to_back();
    reopen();
    checks++;
    if (results_valid !== 1'b1 || count !== last_exp.cnt || total_votes !== last_exp.tot) begin
      errors++; $display("FAIL b2b held: got valid=%b count=%h total=%0d expected 1 %h %0d",
                         results_valid, count, total_votes, last_exp.cnt, last_exp.tot);
    end
    cand_vote[2] = 1'b0;
    tick();
    cand_vote[2] = 1'b1;
    mdl_cnt[2]++;
    checks++;
    if (results_valid !== 1'b0) begin
      errors++; $display("FAIL b2b valid clear: got %b expected 0", results_valid);
    end
    repeat (H) tick();
    close_poll("b2b", '0);
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_spoiled_and_lockout();
    test_saturation();
    test_done_priority();
    test_reset_mid_hold();
`ifdef VM_WINNER_EN
    test_winner();
`endif
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
